// File: rtl/shared_math_unit.sv
// -----------------------------------------------------------------------------
// shared_math_unit
//
// Responder for the shared multiplier and divider buses that the DSP blocks
// (filters, envelopes) drive as initiators. Both units are free-running
// pipelines with no handshake. Operands are sampled on every clock edge, and
// each result appears a fixed number of cycles later. Initiators
// time-multiplex the buses with their own state machines.
//
//   Multiplier: signed 32x32 -> 64, latency 2 (operand register, product
//               register).
//   Divider:    unsigned 48/48 -> 48, latency DIV_LATENCY.
//               Stage 0 is the operand register.
//               Stages 1..24 resolve two quotient bits each, MSB first.
//               Stages 25..DIV_LATENCY-1 are pure delay.
//               Division by zero gives an all-ones quotient.
//
// Parameters:
//   DIV_LATENCY  cycles from div_n/div_d sample to div_q valid (>= 25)
//
// Ports:
//   clk     in   system clock
//   rst     in   asynchronous active-high reset, clears every pipeline stage
//   mult_a  in   [31:0] signed multiplicand
//   mult_b  in   [31:0] signed multiplier
//   mult_p  out  [63:0] signed product, valid two cycles after sampling
//   div_n   in   [47:0] unsigned numerator
//   div_d   in   [47:0] unsigned denominator
//   div_q   out  [47:0] floor(div_n / div_d), valid DIV_LATENCY cycles later
//   div_r   out  [47:0] remainder n - q*d, aligned with div_q
//                       (present only with MATH_UNIT_DIV_REM_EN)
//
// Build option:
//   MATH_UNIT_DIV_REM_EN  when defined, adds the div_r remainder output.
//                         When undefined, the final partial remainder is
//                         dropped and the delay stages carry only the
//                         quotient.
// -----------------------------------------------------------------------------
module shared_math_unit #(
    parameter int DIV_LATENCY = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mult_a,
    input  logic [31:0] mult_b,
    output logic [63:0] mult_p,
    input  logic [47:0] div_n,
    input  logic [47:0] div_d,
    output logic [47:0] div_q
`ifdef MATH_UNIT_DIV_REM_EN
    ,
    output logic [47:0] div_r
`endif
);

    // Stage 0 plus the 23 resolving stages that still carry the full state.
    // Stage 24 is the final resolving stage and keeps only its results.
    localparam int CARRY_STAGES = 24;
    localparam int LAST_CARRY   = CARRY_STAGES - 1;
    localparam int DELAY_STAGES = DIV_LATENCY - 25;

    // -------------------------------------------------------------------------
    // Restoring-division helpers
    // -------------------------------------------------------------------------

    // True when the shifted-in trial remainder can take one more denominator.
    // A set bit 48 can only come from an out-of-range remainder. It is
    // treated as "fits" so that the modular subtraction stays well defined.
    function automatic logic step_fits(input logic [48:0] rem_in,
                                       input logic        num_bit,
                                       input logic [47:0] den);
        logic [48:0] trial;
        trial     = {rem_in[47:0], num_bit};
        step_fits = rem_in[48] | (trial >= {1'b0, den});
    endfunction

    // Partial remainder after one restoring step.
    function automatic logic [48:0] restore_rem(input logic [48:0] rem_in,
                                                input logic        num_bit,
                                                input logic [47:0] den);
        logic [48:0] trial;
        trial = {rem_in[47:0], num_bit};
        if (step_fits(rem_in, num_bit, den)) begin
            restore_rem = trial - {1'b0, den};
        end else begin
            restore_rem = trial;
        end
    endfunction

    // Partial remainder after two restoring steps. bits[1] is consumed first.
    function automatic logic [48:0] step2_rem(input logic [48:0] rem_in,
                                              input logic [1:0]  bits,
                                              input logic [47:0] den);
        step2_rem = restore_rem(restore_rem(rem_in, bits[1], den), bits[0], den);
    endfunction

    // The two quotient bits resolved by a stage, MSB first.
    function automatic logic [1:0] step2_quo(input logic [48:0] rem_in,
                                             input logic [1:0]  bits,
                                             input logic [47:0] den);
        logic [48:0] mid;
        mid       = restore_rem(rem_in, bits[1], den);
        step2_quo = {step_fits(rem_in, bits[1], den), step_fits(mid, bits[0], den)};
    endfunction

    // -------------------------------------------------------------------------
    // Multiplier
    // -------------------------------------------------------------------------
    logic [31:0] mul_a_r;
    logic [31:0] mul_b_r;
    logic [63:0] mul_p_r;
    logic [63:0] mul_a_ext_s;
    logic [63:0] mul_b_ext_s;

    // Sign-extend to 64 bits. The low 64 bits of the unsigned product are
    // then the exact two's-complement signed product.
    assign mul_a_ext_s = {{32{mul_a_r[31]}}, mul_a_r};
    assign mul_b_ext_s = {{32{mul_b_r[31]}}, mul_b_r};

    // Two-stage multiplier pipeline: operand register, then product register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_a_r <= 32'd0;
            mul_b_r <= 32'd0;
            mul_p_r <= 64'd0;
        end else begin
            mul_a_r <= mult_a;
            mul_b_r <= mult_b;
            mul_p_r <= mul_a_ext_s * mul_b_ext_s;
        end
    end

    assign mult_p = mul_p_r;

    // -------------------------------------------------------------------------
    // Divider stages 0..23
    //
    // nq_r holds the numerator bits not yet consumed in its upper part. The
    // quotient bits resolved so far enter at the bottom, so after 24 stages
    // the register holds only the quotient.
    // real_r marks entries loaded from live operands. Reset-state entries
    // (0/0) would otherwise emerge as an all-ones quotient.
    // -------------------------------------------------------------------------
    logic [48:0] rem_r  [0:LAST_CARRY];
    logic [47:0] nq_r   [0:LAST_CARRY];
    logic [47:0] den_r  [0:LAST_CARRY];
    logic        real_r [0:LAST_CARRY];

    // Operand capture plus the first 23 two-bit restoring stages.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CARRY_STAGES; k++) begin
                rem_r[k]  <= 49'd0;
                nq_r[k]   <= 48'd0;
                den_r[k]  <= 48'd0;
                real_r[k] <= 1'b0;
            end
        end else begin
            rem_r[0]  <= 49'd0;
            nq_r[0]   <= div_n;
            den_r[0]  <= div_d;
            real_r[0] <= 1'b1;
            for (int k = 1; k < CARRY_STAGES; k++) begin
                rem_r[k]  <= step2_rem(rem_r[k-1], nq_r[k-1][47:46], den_r[k-1]);
                nq_r[k]   <= {nq_r[k-1][45:0],
                              step2_quo(rem_r[k-1], nq_r[k-1][47:46], den_r[k-1])};
                den_r[k]  <= den_r[k-1];
                real_r[k] <= real_r[k-1];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Divider stage 24: final two quotient bits.
    // Reset-state entries are forced to zero here, so the delay stages
    // need no flag.
    // -------------------------------------------------------------------------
    logic [47:0] fin_q_r;
`ifdef MATH_UNIT_DIV_REM_EN
    logic [47:0] fin_r_r;
`endif

    // Last resolving stage. It zeroes entries that did not come from a live sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fin_q_r <= 48'd0;
`ifdef MATH_UNIT_DIV_REM_EN
            fin_r_r <= 48'd0;
`endif
        end else if (real_r[LAST_CARRY]) begin
            fin_q_r <= {nq_r[LAST_CARRY][45:0],
                        step2_quo(rem_r[LAST_CARRY], nq_r[LAST_CARRY][47:46],
                                  den_r[LAST_CARRY])};
`ifdef MATH_UNIT_DIV_REM_EN
            // The final remainder is below the denominator, so it fits in 48 bits.
            fin_r_r <= 48'(step2_rem(rem_r[LAST_CARRY], nq_r[LAST_CARRY][47:46],
                                     den_r[LAST_CARRY]));
`endif
        end else begin
            fin_q_r <= 48'd0;
`ifdef MATH_UNIT_DIV_REM_EN
            fin_r_r <= 48'd0;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Divider stages 25..DIV_LATENCY-1: alignment delay only
    // -------------------------------------------------------------------------
    generate
        if (DELAY_STAGES > 0) begin : g_delay
            logic [47:0] dly_q_r [0:DELAY_STAGES-1];
`ifdef MATH_UNIT_DIV_REM_EN
            logic [47:0] dly_r_r [0:DELAY_STAGES-1];
`endif

            // Shift register that pads the divider out to DIV_LATENCY.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int k = 0; k < DELAY_STAGES; k++) begin
                        dly_q_r[k] <= 48'd0;
`ifdef MATH_UNIT_DIV_REM_EN
                        dly_r_r[k] <= 48'd0;
`endif
                    end
                end else begin
                    dly_q_r[0] <= fin_q_r;
`ifdef MATH_UNIT_DIV_REM_EN
                    dly_r_r[0] <= fin_r_r;
`endif
                    for (int k = 1; k < DELAY_STAGES; k++) begin
                        dly_q_r[k] <= dly_q_r[k-1];
`ifdef MATH_UNIT_DIV_REM_EN
                        dly_r_r[k] <= dly_r_r[k-1];
`endif
                    end
                end
            end

            assign div_q = dly_q_r[DELAY_STAGES-1];
`ifdef MATH_UNIT_DIV_REM_EN
            assign div_r = dly_r_r[DELAY_STAGES-1];
`endif
        end else begin : g_no_delay
            assign div_q = fin_q_r;
`ifdef MATH_UNIT_DIV_REM_EN
            assign div_r = fin_r_r;
`endif
        end
    endgenerate

endmodule

// File: tb/tb_shared_math_unit.sv
// -----------------------------------------------------------------------------
// tb_shared_math_unit
//
// Directed bench for shared_math_unit. Expected results are pushed to
// per-unit queues with the cycle on which they are due. They are popped and
// compared just after each rising edge. Covers reset behaviour, signed
// multiply, pipelined divides including divide by zero, reset flush and
// reset in mid-operation.
// -----------------------------------------------------------------------------
module tb_shared_math_unit;

    logic        clk;
    logic        rst;
    logic [31:0] mult_a;
    logic [31:0] mult_b;
    logic [63:0] mult_p;
    logic [47:0] div_n;
    logic [47:0] div_d;
    logic [47:0] div_q;
`ifdef MATH_UNIT_DIV_REM_EN
    logic [47:0] div_r;
`endif

    shared_math_unit #(.DIV_LATENCY(30)) dut (
        .clk    (clk),
        .rst    (rst),
        .mult_a (mult_a),
        .mult_b (mult_b),
        .mult_p (mult_p),
        .div_n  (div_n),
        .div_d  (div_d),
        .div_q  (div_q)
`ifdef MATH_UNIT_DIV_REM_EN
        ,
        .div_r  (div_r)
`endif
    );

    localparam logic [47:0] ONES48 = 48'hFFFF_FFFF_FFFF;

    typedef struct {
        int          due;
        logic [63:0] val;
        string       tag;
    } mul_exp_t;

    typedef struct {
        int          due;
        logic [47:0] q;
        logic [47:0] r;
        string       tag;
    } div_exp_t;

    mul_exp_t mq[$];
    div_exp_t dq[$];

    int cyc;
    int n_checks;
    int n_pass;
    int n_fail;

    logic [31:0] ta [10];
    logic [31:0] tb [10];
    logic [47:0] tn [10];
    logic [47:0] td [10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish (%0d failures so far)", n_fail);
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push_m(input int due, input logic [63:0] v, input string tag);
        mul_exp_t e;
        e.due = due;
        e.val = v;
        e.tag = tag;
        mq.push_back(e);
    endtask

    task automatic push_d(input int due, input logic [47:0] q, input logic [47:0] r,
                          input string tag);
        div_exp_t e;
        e.due = due;
        e.q   = q;
        e.r   = r;
        e.tag = tag;
        dq.push_back(e);
    endtask

    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        return longint'(sa) * longint'(sb);
    endfunction

    task automatic div_model(input logic [47:0] n, input logic [47:0] d,
                             output logic [47:0] q, output logic [47:0] r);
        longint unsigned nl;
        longint unsigned dl;
        nl = {16'd0, n};
        dl = {16'd0, d};
        if (d == 48'd0) begin
            q = ONES48;
            r = n;
        end else begin
            q = 48'(nl / dl);
            r = 48'(nl % dl);
        end
    endtask

    // Advance one clock and compare every expectation due on the new cycle.
    task automatic next();
        mul_exp_t me;
        div_exp_t de;
        @(posedge clk);
        #1;
        cyc++;
        while (mq.size() > 0 && mq[0].due <= cyc) begin
            me = mq.pop_front();
            check(me.tag, mult_p, me.val);
        end
        while (dq.size() > 0 && dq[0].due <= cyc) begin
            de = dq.pop_front();
            check({de.tag, "_q"}, {16'd0, div_q}, {16'd0, de.q});
`ifdef MATH_UNIT_DIV_REM_EN
            check({de.tag, "_r"}, {16'd0, div_r}, {16'd0, de.r});
`endif
        end
    endtask

    task automatic drain(input int budget);
        int i;
        i = 0;
        while ((mq.size() > 0 || dq.size() > 0) && i < budget) begin
            next();
            i++;
        end
        check("drain_mult_queue", 64'(mq.size()), 64'd0);
        check("drain_div_queue", 64'(dq.size()), 64'd0);
    endtask

    initial begin
        int          r0;
        int          t0;
        logic [31:0] w1;
        logic [31:0] w2;
        logic [47:0] eq;
        logic [47:0] er;

        cyc      = 0;
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        rst      = 1'b0;
        mult_a   = 32'd0;
        mult_b   = 32'd0;
        div_n    = 48'd0;
        div_d    = 48'd0;

        // Stimulus tables: directed corner cases first, then random.
        ta[0] = 32'h8000_0000; tb[0] = 32'h8000_0000;
        ta[1] = 32'h7FFF_FFFF; tb[1] = 32'h8000_0000;
        ta[2] = 32'hFFFF_FFFF; tb[2] = 32'hFFFF_FFFF;
        ta[3] = 32'd0;         tb[3] = 32'hDEAD_BEEF;
        tn[0] = 48'd100;       td[0] = 48'd7;
        tn[1] = 48'd7;         td[1] = 48'd100;
        tn[2] = 48'd0;         td[2] = 48'd5;
        tn[3] = 48'd5;         td[3] = 48'd0;
        tn[4] = ONES48;        td[4] = 48'd1;
        tn[5] = 48'd12345;     td[5] = 48'd12345;
        for (int i = 4; i < 10; i++) begin
            ta[i] = $urandom;
            tb[i] = $urandom;
        end
        for (int i = 6; i < 10; i++) begin
            w1 = $urandom;
            w2 = $urandom;
            tn[i] = {w1[15:0], w2};
            if (i % 2 == 0) begin
                td[i] = 48'($urandom_range(1, 5000));
            end else begin
                w1 = $urandom;
                td[i] = {16'd0, w1 | 32'd1};
            end
        end

        // Asynchronous reset: outputs clear without a clock edge.
        #1 rst = 1'b1;
        #1;
        check("reset_async_mult", mult_p, 64'd0);
        check("reset_async_div", {16'd0, div_q}, 64'd0);
        next();
        next();
        check("reset_hold_mult", mult_p, 64'd0);
        check("reset_hold_div", {16'd0, div_q}, 64'd0);

        // Release. The divider is fed 0/0 so the flush shows zeros, then all-ones.
        rst    = 1'b0;
        r0     = cyc;
        mult_a = 32'd1000;
        mult_b = 32'd1686629713;
        div_n  = 48'd0;
        div_d  = 48'd0;
        check("flush_zero_c0", {16'd0, div_q}, 64'd0);
        push_m(r0 + 1, 64'd0, "mul_first_zero");
        push_m(r0 + 2, 64'd1686629713000, "mul_basic");
        for (int k = 1; k < 30; k++) push_d(r0 + k, 48'd0, 48'd0, "flush_zero");
        for (int k = 30; k < 33; k++) push_d(r0 + k, ONES48, 48'd0, "flush_ones");

        next();
        mult_a = 32'hFFFF_FFFE;
        mult_b = 32'd3;
        push_m(cyc + 2, 64'hFFFF_FFFF_FFFF_FFFA, "mul_neg_pos");

        next();
        mult_a = 32'hFFFF_0000;
        mult_b = 32'hFFFF_0000;
        push_m(cyc + 2, 64'h0000_0001_0000_0000, "mul_neg_neg");

        // Single large divide, surrounded by X operands on the multiplier and the divider.
        next();
        mult_a = 'x;
        mult_b = 'x;
        div_n  = ONES48;
        div_d  = 48'd24576000;
        push_d(cyc + 30, 48'd11453246, 48'd3014655, "div_big");

        next();
        div_n = 'x;
        div_d = 'x;

        // Back-to-back operands on both units.
        for (int i = 0; i < 10; i++) begin
            next();
            mult_a = ta[i];
            mult_b = tb[i];
            div_n  = tn[i];
            div_d  = td[i];
            push_m(cyc + 2, mul_model(ta[i], tb[i]), $sformatf("mul_tab%0d", i));
            div_model(tn[i], td[i], eq, er);
            push_d(cyc + 30, eq, er, $sformatf("div_tab%0d", i));
        end

        next();
        mult_a = 32'd0;
        mult_b = 32'd0;
        div_n  = 48'd0;
        div_d  = 48'd1;
        drain(100);

        // Reset in mid-operation. No in-flight result may survive it.
        next();
        t0     = cyc;
        mult_a = 32'd7;
        mult_b = 32'd9;
        div_n  = 48'd1000;
        div_d  = 48'd3;
        push_m(t0 + 1, 64'd0, "midrst_mul_pre");
        for (int k = 2; k <= 10; k++) push_m(t0 + k, 64'd63, "midrst_mul_run");
        push_m(t0 + 11, 64'd0, "midrst_mul_in_rst");
        push_m(t0 + 12, 64'd0, "midrst_mul_release");
        push_m(t0 + 13, 64'd0, "midrst_mul_flushed");
        push_m(t0 + 14, 64'd63, "midrst_mul_new");
        for (int k = 1; k <= 41; k++) push_d(t0 + k, 48'd0, 48'd0, "midrst_div_zero");
        push_d(t0 + 42, ONES48, 48'd0, "midrst_div_first_new");

        next();
        div_n = 48'd0;
        div_d = 48'd0;
        while (cyc < t0 + 10) next();
        rst = 1'b1;
        #1;
        check("midrst_async_mult", mult_p, 64'd0);
        check("midrst_async_div", {16'd0, div_q}, 64'd0);
        while (cyc < t0 + 12) next();
        rst = 1'b0;
        drain(100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
